// File: rtl/ctrl_decode_seq_pkg.sv
// Shared types and default widths for the programmable control decoder/sequencer.
// The two-state FSM encoding and the default table entry layout live here.
package ctrl_decode_pkg;

    localparam int OP_W_DEF   = 7;
    localparam int CTRL_W_DEF = 26;
    localparam int BEAT_W_DEF = 3;
    localparam int CNT_W_DEF  = 16;

    // Table entry layout at the default widths; the table stores {ctrl, beats} in this order.
    typedef struct packed {
        logic [CTRL_W_DEF-1:0] ctrl;
        logic [BEAT_W_DEF-1:0] beats;
    } entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/ctrl_decode_seq_if.sv
// Opcode-in / control-beat-out handshake bundle between the front-end and the decoder.
// The master side is the front-end plus the control consumer; the slave side is the decoder.
interface ctrl_decode_seq_if #(
    parameter int OP_W   = 7,
    parameter int CTRL_W = 26,
    parameter int BEAT_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [BEAT_W-1:0] out_beat;
    logic              out_last;

    modport master (
        output in_valid, in_op, out_ready,
        input  in_ready, out_valid, out_ctrl, out_beat, out_last
    );

    modport slave (
        input  in_valid, in_op, out_ready,
        output in_ready, out_valid, out_ctrl, out_beat, out_last
    );
endinterface

// File: rtl/ctrl_decode_seq_table.sv
// Opcode-indexed control table: flop array with async clear, one sync write port and one
// combinational read port (a same-cycle write is seen by readers only after the clock edge).
module ctrl_decode_table #(
    parameter int OP_W   = 7,
    parameter int CTRL_W = 26,
    parameter int BEAT_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [OP_W-1:0]   waddr_i,
    input  logic [CTRL_W-1:0] wctrl_i,
    input  logic [BEAT_W-1:0] wbeats_i,
    input  logic [OP_W-1:0]   raddr_i,
    output logic [CTRL_W-1:0] rctrl_o,
    output logic [BEAT_W-1:0] rbeats_o
);
    localparam int DEPTH = 1 << OP_W;

    logic [CTRL_W-1:0] ctrl_q  [DEPTH];
    logic [BEAT_W-1:0] beats_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_q[i]  <= '0;
                beats_q[i] <= '0;
            end
        end else if (we_i) begin
            ctrl_q[waddr_i]  <= wctrl_i;
            beats_q[waddr_i] <= wbeats_i;
        end
    end

    assign rctrl_o  = ctrl_q[raddr_i];
    assign rbeats_o = beats_q[raddr_i];

endmodule

// File: rtl/ctrl_decode_seq.sv
// Registered, table-driven control decoder: accepts an opcode, looks up {ctrl, beats} and issues
// the control word as a multi-beat sequence; zero-beat entries are flagged illegal and counted.
module ctrl_decode_seq
    import ctrl_decode_pkg::*;
#(
    parameter int OP_W   = OP_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int BEAT_W = BEAT_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    ctrl_decode_seq_if.slave  bus,
    input  logic              cfg_we,
    input  logic [OP_W-1:0]   cfg_addr,
    input  logic [CTRL_W-1:0] cfg_ctrl,
    input  logic [BEAT_W-1:0] cfg_beats,
    output logic              err_illegal,
    output logic [CNT_W-1:0]  illegal_cnt
);
    localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    state_t            state_q, state_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [BEAT_W-1:0] beats_q, beats_d;
    logic [BEAT_W-1:0] beat_q,  beat_d;
    logic              err_q,   err_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic [CTRL_W-1:0] rd_ctrl;
    logic [BEAT_W-1:0] rd_beats;
    logic              last_beat;
    logic              out_hs;
    logic              accept;

    ctrl_decode_table #(
        .OP_W   (OP_W),
        .CTRL_W (CTRL_W),
        .BEAT_W (BEAT_W)
    ) u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (cfg_we),
        .waddr_i  (cfg_addr),
        .wctrl_i  (cfg_ctrl),
        .wbeats_i (cfg_beats),
        .raddr_i  (bus.in_op),
        .rctrl_o  (rd_ctrl),
        .rbeats_o (rd_beats)
    );

    // The op in flight runs from its latched copy so table rewrites cannot disturb it.
    assign last_beat    = (state_q == ISSUE) && (beat_q == beats_q - BEAT_ONE);
    assign out_hs       = (state_q == ISSUE) && bus.out_ready;
    assign bus.in_ready = (state_q == IDLE) || (out_hs && last_beat);
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_valid = (state_q == ISSUE);
    assign bus.out_ctrl  = ctrl_q;
    assign bus.out_beat  = beat_q;
    assign bus.out_last  = last_beat;
    assign err_illegal   = err_q;
    assign illegal_cnt   = cnt_q;

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        beats_d = beats_q;
        beat_d  = beat_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;

        if (out_hs) begin
            if (last_beat) begin
                beat_d  = '0;
                state_d = IDLE;
            end else begin
                beat_d = beat_q + BEAT_ONE;
            end
        end

        // Accept can only happen from IDLE or on the last handshake, so it overrides the above.
        if (accept) begin
            if (rd_beats != '0) begin
                state_d = ISSUE;
                ctrl_d  = rd_ctrl;
                beats_d = rd_beats;
                beat_d  = '0;
            end else begin
                state_d = IDLE;
                err_d   = 1'b1;
                cnt_d   = sat_inc(cnt_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            beats_q <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            beats_q <= beats_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // A stalled beat must stay put until the consumer takes it.
    a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
        bus.out_valid && !bus.out_ready |=>
            bus.out_valid && $stable(bus.out_ctrl) && $stable(bus.out_beat) && $stable(bus.out_last));

    a_err_idle: assert property (@(posedge clk) disable iff (!rst_n)
        err_illegal |-> !bus.out_valid);

endmodule

// File: tb/tb_ctrl_decode_seq.sv
// Directed bench for ctrl_decode_seq: illegal ops, multi-beat issue, back-to-back ops,
// back-pressure, same-cycle table rewrite, mid-sequence reset and counter saturation.
module tb_ctrl_decode_seq;
    localparam int OP_W   = 7;
    localparam int CTRL_W = 26;
    localparam int BEAT_W = 3;
    localparam int CNT_W  = 2;

    localparam logic [CTRL_W-1:0] CTRL_A = 26'h2AAAAAA;
    localparam logic [CTRL_W-1:0] CTRL_B = 26'h155;
    localparam logic [CTRL_W-1:0] CTRL_C = 26'h0123456;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_we;
    logic [OP_W-1:0]   cfg_addr;
    logic [CTRL_W-1:0] cfg_ctrl;
    logic [BEAT_W-1:0] cfg_beats;
    logic              err_illegal;
    logic [CNT_W-1:0]  illegal_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    ctrl_decode_seq_if #(.OP_W(OP_W), .CTRL_W(CTRL_W), .BEAT_W(BEAT_W)) bus ();

    ctrl_decode_seq #(
        .OP_W   (OP_W),
        .CTRL_W (CTRL_W),
        .BEAT_W (BEAT_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_ctrl    (cfg_ctrl),
        .cfg_beats   (cfg_beats),
        .err_illegal (err_illegal),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_beat(input string tag, input logic [CTRL_W-1:0] ctrl,
                              input int beat, input logic last);
        check_val({tag, " valid"}, 32'(bus.out_valid), 32'd1);
        check_val({tag, " ctrl"},  32'(bus.out_ctrl),  32'(ctrl));
        check_val({tag, " beat"},  32'(bus.out_beat),  32'(beat));
        check_val({tag, " last"},  32'(bus.out_last),  32'(last));
    endtask

    task automatic program_entry(input logic [OP_W-1:0] a, input logic [CTRL_W-1:0] c,
                                 input logic [BEAT_W-1:0] b);
        cfg_we = 1'b1; cfg_addr = a; cfg_ctrl = c; cfg_beats = b;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Sends op with out_ready=1 from the current negedge and checks every beat; ends idle.
    task automatic run_op(input string tag, input logic [OP_W-1:0] op,
                          input logic [CTRL_W-1:0] ctrl, input int nbeats);
        bus.in_valid = 1'b1; bus.in_op = op; bus.out_ready = 1'b1;
        for (int b = 0; b < nbeats; b++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            check_beat(tag, ctrl, b, b == nbeats - 1);
            check_val({tag, " in_ready"}, 32'(bus.in_ready), 32'(b == nbeats - 1));
        end
        @(negedge clk);
        check_val({tag, " idle"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = '0; bus.out_ready = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_ctrl = '0; cfg_beats = '0;
        repeat (3) @(negedge clk);
        check_val("rst in_ready",  32'(bus.in_ready),  32'd1);
        check_val("rst out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst out_ctrl",  32'(bus.out_ctrl),  32'd0);
        check_val("rst out_beat",  32'(bus.out_beat),  32'd0);
        check_val("rst out_last",  32'(bus.out_last),  32'd0);
        check_val("rst err",       32'(err_illegal),   32'd0);
        check_val("rst cnt",       32'(illegal_cnt),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Unprogrammed op is illegal: single err pulse, count 1.
        bus.in_valid = 1'b1; bus.in_op = 7'd5;
        #1 check_val("t1 in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_val("t1 err",       32'(err_illegal),   32'd1);
        check_val("t1 out_valid", 32'(bus.out_valid), 32'd0);
        check_val("t1 cnt",       32'(illegal_cnt),   32'd1);
        @(negedge clk);
        check_val("t1 err drop",  32'(err_illegal),   32'd0);
        check_val("t1 cnt hold",  32'(illegal_cnt),   32'd1);

        program_entry(7'd5, CTRL_A, 3'd3);
        program_entry(7'd9, CTRL_B, 3'd1);

        run_op("t2", 7'd5, CTRL_A, 3);

        // Op 5 then op 9 with no bubble between them.
        bus.in_valid = 1'b1; bus.in_op = 7'd5; bus.out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1 check_beat("t3 op5", CTRL_A, b, b == 2);
            if (b == 2) begin
                bus.in_valid = 1'b1; bus.in_op = 7'd9;
                #1 check_val("t3 in_ready", 32'(bus.in_ready), 32'd1);
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 check_beat("t3 op9", CTRL_B, 0, 1'b1);
        @(negedge clk);
        check_val("t3 idle", 32'(bus.out_valid), 32'd0);
        check_val("t3 err",  32'(err_illegal),   32'd0);

        // Back-pressure: out_ready alternates 0/1; beats hold while stalled.
        begin
            int eb = 0;
            bus.in_valid = 1'b1; bus.in_op = 7'd5; bus.out_ready = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.out_ready = (k % 2 == 1);
                #1;
                check_beat("t4", CTRL_A, eb, eb == 2);
                check_val("t4 in_ready", 32'(bus.in_ready), 32'(bus.out_ready && eb == 2));
                if (bus.out_ready) eb++;
            end
            @(negedge clk);
            check_val("t4 idle", 32'(bus.out_valid), 32'd0);
        end

        // Rewrite op 5 in the accept cycle: the running sequence keeps the old entry.
        cfg_we = 1'b1; cfg_addr = 7'd5; cfg_ctrl = CTRL_C; cfg_beats = 3'd2;
        bus.in_valid = 1'b1; bus.in_op = 7'd5; bus.out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            cfg_we = 1'b0; bus.in_valid = 1'b0;
            #1 check_beat("t5 old", CTRL_A, b, b == 2);
        end
        @(negedge clk);
        check_val("t5 idle", 32'(bus.out_valid), 32'd0);
        run_op("t5 new", 7'd5, CTRL_C, 2);

        // Reset during beat 1 aborts at once and clears table and counter.
        bus.in_valid = 1'b1; bus.in_op = 7'd5; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1 check_beat("t6 pre", CTRL_C, 1, 1'b1);
        rst_n = 1'b0;
        #1;
        check_val("t6 abort valid", 32'(bus.out_valid), 32'd0);
        check_val("t6 abort cnt",   32'(illegal_cnt),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Op 5 is illegal again; five in a row saturate the 2-bit counter at 3.
        bus.in_valid = 1'b1; bus.in_op = 7'd5;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check_val("t6 err",   32'(err_illegal),   32'd1);
            check_val("t6 valid", 32'(bus.out_valid), 32'd0);
            check_val("t6 cnt",   32'(illegal_cnt),   32'((k > 3) ? 3 : k));
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_val("t6 err drop", 32'(err_illegal), 32'd0);
        check_val("t6 cnt sat",  32'(illegal_cnt), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
